// File: rtl/voice_pkg.sv
// Shared definitions for the voice frame packer: FSM states, the default
// frame marker and the payload counter width.
package voice_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAGIC,
        ST_SEQ,
        ST_TS,
        ST_PAY,
        ST_CSUM
    } state_t;

    localparam logic [15:0] DEF_MAGIC = 16'hA55A;
    localparam int unsigned LEN_W     = 12;

endpackage

// File: rtl/vfp_out_reg.sv
// One-entry valid/ready output register carrying a data word and its
// start/end-of-frame qualifiers; holds everything stable while stalled.
module vfp_out_reg (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_sof,
    input  logic        in_eof,
    output logic        load,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [15:0] o_data,
    output logic        o_sof,
    output logic        o_eof
);

    always_comb begin
        load = !o_valid || i_ready;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
        end else if (load) begin
            o_valid <= in_valid;
            if (in_valid) begin
                o_data <= in_data;
            end
            o_sof   <= in_valid && in_sof;
            o_eof   <= in_valid && in_eof;
        end
    end

endmodule

// File: rtl/voice_frame_packer.sv
// Packs 16-bit voice samples into frames: MAGIC, SEQ, TS, FRAME_LEN samples,
// then a 16-bit payload checksum. Every state step is gated by an output load.
module voice_frame_packer
    import voice_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 160,
    parameter logic [15:0] MAGIC     = DEF_MAGIC,
    parameter logic [15:0] SEQ_INIT  = 16'd0
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_ts,
    input  logic        i_smp_valid,
    input  logic [15:0] i_smp_data,
    output logic        o_smp_ready,
    output logic        o_valid,
    output logic [15:0] o_data,
    output logic        o_sof,
    output logic        o_eof,
    input  logic        i_ready,
    output logic [15:0] o_frames
);

    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(FRAME_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      seq;
    logic [15:0]      ts_lat;
    logic [15:0]      csum;
    logic [LEN_W-1:0] pay_cnt;

    logic             load;
    logic             ld_valid;
    logic [15:0]      ld_data;
    logic             ld_sof;
    logic             ld_eof;
    logic             smp_fire;

    always_comb begin
        o_smp_ready = (state == ST_PAY) && load;
        smp_fire    = i_smp_valid && o_smp_ready;
    end

    always_comb begin
        state_nxt = state;
        ld_valid  = 1'b0;
        ld_data   = '0;
        ld_sof    = 1'b0;
        ld_eof    = 1'b0;
        case (state)
            ST_IDLE: begin
                // The first sample only opens the frame; it is consumed in PAY.
                if (i_smp_valid && load) begin
                    state_nxt = ST_MAGIC;
                end
            end
            ST_MAGIC: begin
                ld_valid = 1'b1;
                ld_data  = MAGIC;
                ld_sof   = 1'b1;
                if (load) begin
                    state_nxt = ST_SEQ;
                end
            end
            ST_SEQ: begin
                ld_valid = 1'b1;
                ld_data  = seq;
                if (load) begin
                    state_nxt = ST_TS;
                end
            end
            ST_TS: begin
                ld_valid = 1'b1;
                ld_data  = ts_lat;
                if (load) begin
                    state_nxt = ST_PAY;
                end
            end
            ST_PAY: begin
                ld_valid = i_smp_valid;
                ld_data  = i_smp_data;
                if (smp_fire && (pay_cnt == LAST_IDX)) begin
                    state_nxt = ST_CSUM;
                end
            end
            ST_CSUM: begin
                ld_valid = 1'b1;
                ld_data  = csum;
                ld_eof   = 1'b1;
                if (load) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            seq      <= SEQ_INIT;
            ts_lat   <= '0;
            csum     <= '0;
            pay_cnt  <= '0;
            o_frames <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && (state_nxt == ST_MAGIC)) begin
                ts_lat  <= i_ts;
                csum    <= '0;
                pay_cnt <= '0;
            end
            if (smp_fire) begin
                csum    <= csum + i_smp_data;
                pay_cnt <= pay_cnt + LEN_W'(1);
            end
            if ((state == ST_CSUM) && load) begin
                seq      <= seq + 16'd1;
                o_frames <= o_frames + 16'd1;
            end
        end
    end

    vfp_out_reg u_out (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .in_valid (ld_valid),
        .in_data  (ld_data),
        .in_sof   (ld_sof),
        .in_eof   (ld_eof),
        .load     (load),
        .i_ready  (i_ready),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_sof    (o_sof),
        .o_eof    (o_eof)
    );

endmodule

// File: tb/tb_voice_frame_packer.sv
// Scoreboard bench for voice_frame_packer: two instances (SEQ_INIT 0 and FFFF)
// share one stimulus stream; a frame-level model fills per-instance queues.
module tb_voice_frame_packer;

    localparam int unsigned FL   = 4;
    localparam logic [15:0] SI_A = 16'h0000;
    localparam logic [15:0] SI_B = 16'hFFFF;
    localparam logic [15:0] MGC  = 16'hA55A;

    typedef struct packed {
        logic [15:0] d;
        logic        sof;
        logic        eof;
    } exp_t;
    typedef logic [15:0] pay_t [FL];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ts;
    logic        smp_valid;
    logic [15:0] smp_data;
    logic        rdy;
    logic [1:0]  smp_ready;
    logic [1:0]  vld;
    logic [1:0]  sof;
    logic [1:0]  eof;
    logic [15:0] dat    [2];
    logic [15:0] frames [2];

    exp_t        q [2][$];
    logic [15:0] seq_m [2];
    int unsigned eofs  [2];
    int unsigned n_cmp;
    int unsigned n_bad;
    bit          rand_rdy;

    always #5 clk = ~clk;

    voice_frame_packer #(.FRAME_LEN(FL), .SEQ_INIT(SI_A)) dut_a (
        .clk(clk), .i_rst_n(rst_n), .i_ts(ts), .i_smp_valid(smp_valid), .i_smp_data(smp_data),
        .o_smp_ready(smp_ready[0]), .o_valid(vld[0]), .o_data(dat[0]), .o_sof(sof[0]),
        .o_eof(eof[0]), .i_ready(rdy), .o_frames(frames[0])
    );

    voice_frame_packer #(.FRAME_LEN(FL), .SEQ_INIT(SI_B)) dut_b (
        .clk(clk), .i_rst_n(rst_n), .i_ts(ts), .i_smp_valid(smp_valid), .i_smp_data(smp_data),
        .o_smp_ready(smp_ready[1]), .o_valid(vld[1]), .o_data(dat[1]), .o_sof(sof[1]),
        .o_eof(eof[1]), .i_ready(rdy), .o_frames(frames[1])
    );

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    // Every cycle with o_valid is compared against the queue head, so a
    // stalled word must keep matching until it is accepted and popped.
    task automatic check_port(input int k, input logic v, input logic [15:0] d,
                              input logic s, input logic e, input logic [15:0] fr);
        exp_t x;
        if (!v) return;
        n_cmp++;
        if (q[k].size() == 0) begin
            n_bad++;
            $display("FAIL out%0d_extra got %h sof=%0b eof=%0b want nothing", k, d, s, e);
            return;
        end
        x = q[k][0];
        if ({d, s, e} !== {x.d, x.sof, x.eof}) begin
            n_bad++;
            $display("FAIL out%0d_word got %h sof=%0b eof=%0b want %h sof=%0b eof=%0b",
                     k, d, s, e, x.d, x.sof, x.eof);
        end
        if (x.eof) begin
            chk($sformatf("out%0d_frames", k), fr, 16'(eofs[k] + 1));
        end
        if (rdy) begin
            void'(q[k].pop_front());
            if (x.eof) eofs[k]++;
        end
    endtask

    initial begin
        rdy = 1'b1;
        forever begin
            @(negedge clk);
            rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                check_port(0, vld[0], dat[0], sof[0], eof[0], frames[0]);
                check_port(1, vld[1], dat[1], sof[1], eof[1], frames[1]);
            end
        end
    end

    task automatic send_sample(input logic [15:0] d, input bit gaps, output bit ok);
        int unsigned t = 0;
        ok = 1'b0;
        while (!ok && t < 300) begin
            @(negedge clk);
            smp_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            smp_data  = smp_valid ? d : 16'($urandom);
            #1;
            ok = smp_valid && smp_ready[0];
            t++;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sample_accept got timeout want handshake within 300 cycles");
        end
    endtask

    // Frame model: header from the chosen ts and per-instance sequence count,
    // payload verbatim, checksum as the payload sum modulo 65536.
    task automatic run_frame(input logic [15:0] ts_v, input pay_t s, input bit gaps,
                             input bit jit, input int unsigned stop_after, input bit lit);
        int unsigned sum = 0;
        int          k0  = lit ? 1 : 0;
        bit          ok;
        ts = ts_v;
        for (int k = k0; k < 2; k++) begin
            q[k].push_back({MGC, 1'b1, 1'b0});
            q[k].push_back({seq_m[k], 1'b0, 1'b0});
            q[k].push_back({ts_v, 1'b0, 1'b0});
        end
        for (int unsigned i = 0; i < FL; i++) begin
            if (i == stop_after) return;
            for (int k = k0; k < 2; k++) q[k].push_back({s[i], 1'b0, 1'b0});
            sum = sum + s[i];
            send_sample(s[i], gaps, ok);
            if (jit) ts = 16'($urandom);
        end
        for (int k = k0; k < 2; k++) begin
            q[k].push_back({16'(sum % 65536), 1'b0, 1'b1});
            seq_m[k] = seq_m[k] + 16'd1;
        end
    endtask

    task automatic drain();
        int unsigned t = 0;
        @(negedge clk);
        smp_valid = 1'b0;
        while ((q[0].size() != 0 || q[1].size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_a", 16'(q[0].size()), 16'd0);
        chk("drain_b", 16'(q[1].size()), 16'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_valid%0d", tag, k), 16'(vld[k]), 16'd0);
            chk($sformatf("%s_data%0d", tag, k), dat[k], 16'd0);
            chk($sformatf("%s_sof%0d", tag, k), 16'(sof[k]), 16'd0);
            chk($sformatf("%s_eof%0d", tag, k), 16'(eof[k]), 16'd0);
            chk($sformatf("%s_frames%0d", tag, k), frames[k], 16'd0);
            chk($sformatf("%s_smp_ready%0d", tag, k), 16'(smp_ready[k]), 16'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pay_t p;
        exp_t lit1 [8];
        n_cmp     = 0;
        n_bad     = 0;
        rand_rdy  = 1'b0;
        rst_n     = 1'b0;
        smp_valid = 1'b0;
        smp_data  = '0;
        ts        = '0;
        seq_m[0]  = SI_A;
        seq_m[1]  = SI_B;
        eofs[0]   = 0;
        eofs[1]   = 0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, expected words written out literally for instance A.
        lit1 = '{{16'hA55A, 1'b1, 1'b0}, {16'h0000, 1'b0, 1'b0}, {16'h1234, 1'b0, 1'b0},
                 {16'h0001, 1'b0, 1'b0}, {16'h0002, 1'b0, 1'b0}, {16'h0003, 1'b0, 1'b0},
                 {16'h0004, 1'b0, 1'b0}, {16'h000A, 1'b0, 1'b1}};
        foreach (lit1[i]) q[0].push_back(lit1[i]);
        seq_m[0] = seq_m[0] + 16'd1;
        p = '{16'd1, 16'd2, 16'd3, 16'd4};
        run_frame(16'h1234, p, 1'b0, 1'b0, FL, 1'b1);

        // Back-to-back frame, then carry-dropping checksum frame.
        foreach (p[i]) p[i] = 16'($urandom);
        run_frame(16'h5678, p, 1'b0, 1'b0, FL, 1'b0);
        p = '{16'hFFFF, 16'h0002, 16'h0000, 16'h0000};
        run_frame(16'($urandom), p, 1'b0, 1'b0, FL, 1'b0);
        drain();

        // Random backpressure, sample gaps and mid-frame timestamp changes.
        rand_rdy = 1'b1;
        for (int f = 0; f < 50; f++) begin
            foreach (p[i]) p[i] = 16'($urandom);
            run_frame(16'($urandom), p, 1'b1, 1'b1, FL, 1'b0);
        end
        drain();
        rand_rdy = 1'b0;

        // Reset in the middle of the payload, then a fresh frame.
        foreach (p[i]) p[i] = 16'($urandom);
        run_frame(16'h0BAD, p, 1'b0, 1'b0, 2, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        smp_valid = 1'b0;
        q[0].delete();
        q[1].delete();
        seq_m[0] = SI_A;
        seq_m[1] = SI_B;
        eofs[0]  = 0;
        eofs[1]  = 0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (p[i]) p[i] = 16'($urandom);
        run_frame(16'h600D, p, 1'b0, 1'b0, FL, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
